// File: rtl/dribbler_pwm_gen_if.sv
// Interface between the dribbler command processor and the PWM generator.
// master drives the duty/direction command; slave returns the bridge drive and status.
interface dribbler_pwm_gen_if;
    logic        enable;
    logic [31:0] duty_in;
    logic        dir_in;
    logic        in_a;
    logic        in_b;
    logic        busy_dead;
    logic        period_tick;

    modport master (
        output enable, duty_in, dir_in,
        input  in_a, in_b, busy_dead, period_tick
    );

    modport slave (
        input  enable, duty_in, dir_in,
        output in_a, in_b, busy_dead, period_tick
    );
endinterface

// File: rtl/dribbler_pwm_gen.sv
// Dribbler H-bridge PWM generator.
// Latches duty/direction only on period boundaries and inserts a dead interval
// (both bridge inputs low) on a direction reversal with nonzero duty.
// Optional macro DB_SLEW_EN: duty ramps by at most SLEW_STEP per period and a
// reversal ramps to zero first, so the DEAD state is never used.
module dribbler_pwm_gen #(
    parameter int unsigned PERIOD    = 1000,
    parameter int unsigned DUTY_MAX  = 750,
    parameter int unsigned DEADTIME  = 50,
    parameter int unsigned SLEW_STEP = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    dribbler_pwm_gen_if.slave pwm_io
);
    localparam int unsigned CntW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned DutyW = (DUTY_MAX > 0) ? $clog2(DUTY_MAX + 1) : 1;
    localparam int unsigned DeadW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [CntW-1:0]  CntLast  = CntW'(PERIOD - 1);
    localparam logic [DeadW-1:0] DeadLast = DeadW'(DEADTIME - 1);
    localparam logic [DutyW-1:0] DutyCeil = DutyW'(DUTY_MAX);

    typedef enum logic [0:0] {StRun, StDead} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [DeadW-1:0] dead_cnt_q;
    logic [DutyW-1:0] duty_act_q;
    logic             dir_act_q;
    logic             in_a_q;
    logic             in_b_q;
    logic             busy_dead_q;
    logic             period_tick_q;

    logic [DutyW-1:0] duty_clip;
    logic             pwm;
    logic             dir_mismatch;

    // Clip the request (full 32-bit compare) and decode the PWM comparator.
    always_comb begin
        duty_clip    = (pwm_io.duty_in > DUTY_MAX) ? DutyCeil : pwm_io.duty_in[DutyW-1:0];
        pwm          = (state_q == StRun) && (32'(cnt_q) < 32'(duty_act_q));
        dir_mismatch = (pwm_io.dir_in != dir_act_q);
    end

`ifdef DB_SLEW_EN
    logic [DutyW-1:0] slew_target;
    logic [DutyW-1:0] duty_slew;
    int unsigned      slew_cur;
    int unsigned      slew_tgt;
    int unsigned      slew_nxt;

    // Step duty toward the target; a pending reversal targets zero first.
    always_comb begin
        slew_target = (dir_mismatch && (duty_act_q != '0)) ? '0 : duty_clip;
        slew_cur    = 32'(duty_act_q);
        slew_tgt    = 32'(slew_target);
        if (slew_tgt > slew_cur) begin
            slew_nxt = (slew_tgt - slew_cur > SLEW_STEP) ? slew_cur + SLEW_STEP : slew_tgt;
        end else begin
            slew_nxt = (slew_cur - slew_tgt > SLEW_STEP) ? slew_cur - SLEW_STEP : slew_tgt;
        end
        duty_slew = DutyW'(slew_nxt);
    end
`else
    logic unused_slew_step;
    assign unused_slew_step = ^SLEW_STEP;
`endif

    // Period/dead FSM with registered bridge outputs; enable low forces coast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            cnt_q         <= '0;
            dead_cnt_q    <= '0;
            duty_act_q    <= '0;
            dir_act_q     <= 1'b0;
            in_a_q        <= 1'b0;
            in_b_q        <= 1'b0;
            busy_dead_q   <= 1'b0;
            period_tick_q <= 1'b0;
        end else if (!pwm_io.enable) begin
            state_q       <= StRun;
            cnt_q         <= '0;
            dead_cnt_q    <= '0;
            duty_act_q    <= '0;
            in_a_q        <= 1'b0;
            in_b_q        <= 1'b0;
            busy_dead_q   <= 1'b0;
            period_tick_q <= 1'b0;
        end else begin
            // Both bridge inputs derive from one direction bit, so never both high.
            in_a_q        <= pwm & ~dir_act_q;
            in_b_q        <= pwm & dir_act_q;
            busy_dead_q   <= (state_q == StDead);
            period_tick_q <= (state_q == StRun) && (cnt_q == '0);
            unique case (state_q)
                StRun: begin
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
`ifdef DB_SLEW_EN
                        duty_act_q <= duty_slew;
                        if (!(dir_mismatch && (duty_act_q != '0))) begin
                            dir_act_q <= pwm_io.dir_in;
                        end
`else
                        if (dir_mismatch && (duty_act_q != '0)) begin
                            state_q    <= StDead;
                            dead_cnt_q <= '0;
                            duty_act_q <= '0;
                        end else begin
                            duty_act_q <= duty_clip;
                            dir_act_q  <= pwm_io.dir_in;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDead: begin
                    if (dead_cnt_q == DeadLast) begin
                        // Resample at exit so a reverted request is honoured.
                        state_q    <= StRun;
                        cnt_q      <= '0;
                        duty_act_q <= duty_clip;
                        dir_act_q  <= pwm_io.dir_in;
                    end else begin
                        dead_cnt_q <= dead_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign pwm_io.in_a        = in_a_q;
    assign pwm_io.in_b        = in_b_q;
    assign pwm_io.busy_dead   = busy_dead_q;
    assign pwm_io.period_tick = period_tick_q;
endmodule

// File: tb/tb_dribbler_pwm_gen.sv
// Bench for dribbler_pwm_gen: table of steady-state on-times, hand sequences for
// reset/reversal/enable corners, and random stimulus against a period-level model.
module tb_dribbler_pwm_gen;
    localparam int PERIOD    = 10;
    localparam int DUTY_MAX  = 7;
    localparam int DEADTIME  = 3;
    localparam int SLEW_STEP = 2;
`ifdef DB_SLEW_EN
    localparam int SETTLE    = 10;
    localparam int EXP_FIRST = 2;
`else
    localparam int SETTLE    = 1;
    localparam int EXP_FIRST = 5;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dribbler_pwm_gen_if bus ();

    dribbler_pwm_gen #(
        .PERIOD   (PERIOD),
        .DUTY_MAX (DUTY_MAX),
        .DEADTIME (DEADTIME),
        .SLEW_STEP(SLEW_STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_io(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- period-level reference model ----------------
    // The model plans whole segments (one PWM period or one dead interval) as a
    // queue of expected output slots; each clock edge consumes one slot and the
    // last slot of a segment decides the next segment from the current inputs.
    typedef struct packed {
        logic a;
        logic b;
        logic busy;
        logic tick;
        logic last;
        logic dead;
    } slot_t;

    slot_t plan_q[$];
    slot_t cur_s;
    int    m_duty;
    logic  m_dir;
    logic  exp_a = 1'b0, exp_b = 1'b0, exp_busy = 1'b0, exp_tick = 1'b0;

    function automatic int clip(input logic [31:0] x);
        return (x > 32'(DUTY_MAX)) ? DUTY_MAX : int'(x);
    endfunction

    function automatic void push_run(input int d, input logic r);
        slot_t s;
        for (int i = 0; i < PERIOD; i++) begin
            s.a    = (i < d) && !r;
            s.b    = (i < d) && r;
            s.busy = 1'b0;
            s.tick = (i == 0);
            s.last = (i == PERIOD - 1);
            s.dead = 1'b0;
            plan_q.push_back(s);
        end
    endfunction

    function automatic void push_dead();
        slot_t s;
        for (int i = 0; i < DEADTIME; i++) begin
            s.a    = 1'b0;
            s.b    = 1'b0;
            s.busy = 1'b1;
            s.tick = 1'b0;
            s.last = (i == DEADTIME - 1);
            s.dead = 1'b1;
            plan_q.push_back(s);
        end
    endfunction

    function automatic void plan_next(input logic was_dead);
        int tgt;
        tgt = clip(bus.duty_in);
        if (was_dead) begin
            m_duty = tgt;
            m_dir  = bus.dir_in;
            push_run(m_duty, m_dir);
        end else begin
`ifdef DB_SLEW_EN
            if (bus.dir_in != m_dir && m_duty != 0) tgt = 0;
            else m_dir = bus.dir_in;
            if (tgt > m_duty) m_duty = (tgt - m_duty > SLEW_STEP) ? m_duty + SLEW_STEP : tgt;
            else m_duty = (m_duty - tgt > SLEW_STEP) ? m_duty - SLEW_STEP : tgt;
            push_run(m_duty, m_dir);
`else
            if (bus.dir_in != m_dir && m_duty != 0) begin
                m_duty = 0;
                push_dead();
            end else begin
                m_duty = tgt;
                m_dir  = bus.dir_in;
                push_run(m_duty, m_dir);
            end
`endif
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plan_q.delete();
            m_duty = 0;
            m_dir  = 1'b0;
            push_run(0, 1'b0);
            {exp_a, exp_b, exp_busy, exp_tick} = 4'b0;
        end else if (!bus.enable) begin
            plan_q.delete();
            m_duty = 0;
            push_run(0, m_dir);
            {exp_a, exp_b, exp_busy, exp_tick} = 4'b0;
        end else begin
            cur_s = plan_q.pop_front();
            {exp_a, exp_b, exp_busy, exp_tick} = {cur_s.a, cur_s.b, cur_s.busy, cur_s.tick};
            if (cur_s.last) plan_next(cur_s.dead);
        end
    end

    // Per-cycle comparison against the model, sampled away from the active edge.
    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("model {a,b,busy,tick}",
                  32'({bus.in_a, bus.in_b, bus.busy_dead, bus.period_tick}),
                  32'({exp_a, exp_b, exp_busy, exp_tick}));
            check("a_and_b_exclusive", 32'(bus.in_a & bus.in_b), 32'd0);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_tick();
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.period_tick !== 1'b1 && guard < 4 * PERIOD) begin
            @(negedge clk);
            guard++;
        end
        if (bus.period_tick !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_wait: no period_tick after %0d cycles, required a pulse", guard);
        end
    endtask

    // Count on-cycles over one whole period starting at the next period_tick.
    task automatic measure(output int on_a, output int on_b);
        wait_tick();
        on_a = 0;
        on_b = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            on_a += int'(bus.in_a);
            on_b += int'(bus.in_b);
        end
    endtask

    task automatic settle();
        int da, db;
        repeat (SETTLE) measure(da, db);
    endtask

    typedef struct {
        logic [31:0] duty;
        logic        dir;
        int          exp_a;
        int          exp_b;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int oa, ob, busy_cnt;
        int ramp_a[9];
        int ramp_b[9];

        tbl[0] = '{32'd5,          1'b0, 5, 0};
        tbl[1] = '{32'd20,         1'b0, 7, 0};
        tbl[2] = '{32'hFFFF_FFFF,  1'b0, 7, 0};
        tbl[3] = '{32'd0,          1'b0, 0, 0};
        tbl[4] = '{32'd4,          1'b1, 0, 4};
        tbl[5] = '{32'd8,          1'b1, 0, 7};
        tbl[6] = '{32'd7,          1'b0, 7, 0};
        tbl[7] = '{32'd1,          1'b1, 0, 1};
        tbl[8] = '{32'd2,          1'b0, 2, 0};
        tbl[9] = '{32'd6,          1'b0, 6, 0};

        // 1. Reset held with an active request: everything stays low.
        rst_n       = 1'b0;
        bus.enable  = 1'b1;
        bus.duty_in = 32'd5;
        bus.dir_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_a", 32'(bus.in_a), 32'd0);
        check("rst_in_b", 32'(bus.in_b), 32'd0);
        check("rst_busy_dead", 32'(bus.busy_dead), 32'd0);
        check("rst_period_tick", 32'(bus.period_tick), 32'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        measure(oa, ob);
        check("first_period_a", 32'(oa), 32'd0);
        measure(oa, ob);
        check("second_period_a", 32'(oa), 32'(EXP_FIRST));
        check("second_period_b", 32'(ob), 32'd0);

        // 2. Steady-state table, including clipping and direction changes.
        for (int k = 0; k < 10; k++) begin
            bus.duty_in = tbl[k].duty;
            bus.dir_in  = tbl[k].dir;
            settle();
            measure(oa, ob);
            check($sformatf("tbl%0d_on_a", k), 32'(oa), 32'(tbl[k].exp_a));
            check($sformatf("tbl%0d_on_b", k), 32'(ob), 32'(tbl[k].exp_b));
        end

`ifndef DB_SLEW_EN
        // 3. Mid-period reversal: period finishes, dead interval, then in_b.
        bus.duty_in = 32'd4;
        bus.dir_in  = 1'b0;
        settle();
        measure(oa, ob);
        check("rev_steady_a", 32'(oa), 32'd4);
        wait_tick();
        oa = 0;
        ob = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            oa += int'(bus.in_a);
            ob += int'(bus.in_b);
            if (i == 4) bus.dir_in = 1'b1;
        end
        check("rev_pre_a", 32'(oa), 32'd4);
        check("rev_pre_b", 32'(ob), 32'd0);
        for (int i = 0; i < DEADTIME; i++) begin
            @(negedge clk);
            check("dead_busy", 32'(bus.busy_dead), 32'd1);
            check("dead_ab", 32'({bus.in_a, bus.in_b}), 32'd0);
        end
        @(negedge clk);
        check("dead_exit_busy", 32'(bus.busy_dead), 32'd0);
        check("dead_exit_tick", 32'(bus.period_tick), 32'd1);
        measure(oa, ob);
        check("rev_post_a", 32'(oa), 32'd0);
        check("rev_post_b", 32'(ob), 32'd4);
`endif

        // 4. Zero-duty reversal: no dead interval at all.
        bus.duty_in = 32'd0;
        settle();
        measure(oa, ob);
        bus.dir_in = ~bus.dir_in;
        busy_cnt = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            busy_cnt += int'(bus.busy_dead);
        end
        check("zero_rev_busy_cycles", 32'(busy_cnt), 32'd0);
        bus.dir_in  = 1'b0;
        bus.duty_in = 32'd3;
        settle();
        measure(oa, ob);
        check("zero_rev_after_a", 32'(oa), 32'd3);

        // 5. Enable drop at cnt==2 with duty 6.
        bus.duty_in = 32'd6;
        settle();
        measure(oa, ob);
        check("en_before_a", 32'(oa), 32'd6);
        wait_tick();
        @(negedge clk);
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en_low_ab", 32'({bus.in_a, bus.in_b}), 32'd0);
        end
        bus.enable = 1'b1;
        measure(oa, ob);
        check("en_resume_low_period", 32'(oa), 32'd0);
        measure(oa, ob);
        check("en_resume_a", 32'(oa), 32'(EXP_FIRST == 5 ? 6 : 2));

`ifdef DB_SLEW_EN
        // 6. Slew ramp up, ramp down through a reversal, ramp up the other way.
        ramp_a = '{0, 2, 4, 6, 7, 7, 5, 3, 1};
        ramp_b = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        bus.duty_in = 32'd7;
        bus.dir_in  = 1'b0;
        bus.enable  = 1'b0;
        @(negedge clk);
        bus.enable  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            measure(oa, ob);
            if (i == 4) bus.dir_in = 1'b1;
            check($sformatf("slew%0d_a", i), 32'(oa), 32'(ramp_a[i]));
            check($sformatf("slew%0d_b", i), 32'(ob), 32'(ramp_b[i]));
        end
        measure(oa, ob);
        check("slew_zero_a", 32'(oa), 32'd0);
        check("slew_zero_b", 32'(ob), 32'd0);
        measure(oa, ob);
        check("slew_up1_b", 32'(ob), 32'd2);
        measure(oa, ob);
        check("slew_up2_b", 32'(ob), 32'd4);
        check("slew_up2_a", 32'(oa), 32'd0);
`else
        ramp_a = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        ramp_b = ramp_a;
`endif

        // 7. Random stimulus; the model checker does the comparing.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 9) == 0) bus.duty_in = $urandom();
                else bus.duty_in = 32'($urandom_range(0, PERIOD + 2));
            end
            if ($urandom_range(0, 39) == 0) bus.dir_in = ~bus.dir_in;
            bus.enable = ($urandom_range(0, 149) != 0);
        end
        bus.enable = 1'b1;
        repeat (2 * PERIOD) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
